// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: word handshake between a producer and uart_tx_cfg.
//   tx_data  : word to send (DATA_BITS wide)
//   tx_valid : producer has a word on tx_data
//   tx_ready : transmitter accepts a word this cycle
// A word moves on any rising clk edge with tx_valid && tx_ready.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter, LSB first.
// Frame: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
// Each bit lasts OVERSAMPLE baud_tick pulses.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   baud_tick  : single-clk oversample strobe
//   txif       : uart_tx_cfg_if.slave (tx_data / tx_valid / tx_ready)
//   tx         : serial line, idle high
//   busy       : FSM not in IDLE
//   done       : one-clk pulse when the frame's last stop bit ends
// Build option: define UART_TX_FIFO_EN for a 4-entry input FIFO; then
// tx_ready means "FIFO not full" instead of "FSM idle".
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_tick,
  uart_tx_cfg_if.slave  txif,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int CW = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [CW-1:0]        bit_cnt;   // data bit index in DATA, stop bit index in STOP
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;
  logic                 take;      // FSM loads a word this cycle
  logic [DATA_BITS-1:0] word;

  assign bit_end = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

`ifdef UART_TX_FIFO_EN
  logic [DATA_BITS-1:0] fifo_mem [4];
  logic [1:0]           wptr, rptr;
  logic [2:0]           count;
  logic                 push, pop;

  assign txif.tx_ready = (count != 3'd4);
  assign push = txif.tx_valid && txif.tx_ready;
  assign pop  = (state == ST_IDLE) && (count != 3'd0);
  assign take = pop;
  assign word = fifo_mem[rptr];

  always_ff @(posedge clk)
    if (push) fifo_mem[wptr] <= txif.tx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end
`else
  // Ready only in IDLE: it drops the cycle after a handshake, so a held
  // tx_valid cannot transfer again until the frame is finished.
  assign txif.tx_ready = (state == ST_IDLE);
  assign take = txif.tx_valid && txif.tx_ready;
  assign word = txif.tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        // baud_tick is ignored here; the bit clock phase starts at load
        if (take) begin
          state    <= ST_START;
          tick_cnt <= '0;
          shreg    <= word;
          // parity is taken from the word before it is shifted out
          par_bit  <= (PARITY == 1) ? ~^word : ^word;
        end
      end else if (baud_tick) begin
        if (!bit_end) begin
          tick_cnt <= tick_cnt + TW'(1);
        end else begin
          tick_cnt <= '0;
          case (state)
            ST_START: state <= ST_DATA;
            ST_DATA: begin
              shreg <= shreg >> 1;
              if (bit_cnt == CW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            ST_PARITY: state <= ST_STOP;
            ST_STOP: begin
              if (bit_cnt == CW'(STOP_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= ST_IDLE;
                done    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
      ST_PARITY: tx = par_bit;
      default:   tx = 1'b1;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg.
// Four instances cover 8N1, 8E1, 8O1 and 5N2. Stimulus pushes the expected
// serial frame (bit vector, LSB = start bit) into a per-instance queue; one
// monitor per instance watches tx, pops on each start bit and compares every
// clock of the frame plus the done pulse that follows it.
module tb_uart_tx_cfg;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          len;
    int          gap;
    bit          may_abort;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       div4;
  logic [1:0] tcnt = 2'd0;
  int         cyc = 0;
  logic [3:0] tx_w, busy_w, done_w, rdy_w, tvalid;
  logic [8:0] tdata;

  int n_tests = 0;
  int n_fail  = 0;

  frame_t exp_q [4][$];

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if3 ();

  assign if0.tx_valid = tvalid[0];  assign if0.tx_data = tdata[7:0];
  assign if1.tx_valid = tvalid[1];  assign if1.tx_data = tdata[7:0];
  assign if2.tx_valid = tvalid[2];  assign if2.tx_data = tdata[7:0];
  assign if3.tx_valid = tvalid[3];  assign if3.tx_data = tdata[4:0];
  assign rdy_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .txif(if0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .txif(if1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .txif(if2),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_cfg #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .txif(if3),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    cyc  <= cyc + 1;
  end

  assign baud_tick = !div4 || (tcnt == 2'd0);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void expect_frame(input int k, input logic [11:0] b, input int n,
                                       input int len, input int gap, input bit ab);
    frame_t f;
    f.bits = b; f.n = n; f.len = len; f.gap = gap; f.may_abort = ab;
    exp_q[k].push_back(f);
  endfunction

  // Present a word on instance k and return one cycle after it is taken.
  // align: start the attempt so the handshake edge carries a baud_tick.
  task automatic send(input int k, input logic [8:0] d, input bit align);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (align)
      for (int c = 0; c < 8 && tcnt != 2'd0; c++) begin @(posedge clk); #1; end
    tdata = d;
    tvalid[k] = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (rdy_w[k]) begin ok = 1'b1; @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
    tvalid[k] = 1'b0;
    if (!ok) chk($sformatf("send timeout d%0d", k), 0, 1);
  endtask

  task automatic wait_idle(input int k);
    int q;
    q = 0;
    for (int c = 0; c < 3000 && q < 3; c++) begin
      @(posedge clk); #1;
      q = busy_w[k] ? 0 : q + 1;
    end
    chk($sformatf("idle d%0d", k), (q >= 3), 1);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial begin
      frame_t e;
      bit     prev;
      bit     ab;
      int     bad;
      int     dn;
      prev = 1'b1;
      dn   = -1000;
      forever begin
        @(negedge clk);
        if (!rst && tx_w[g] === 1'b0 && prev) begin
          if (exp_q[g].size() == 0) begin
            chk($sformatf("unexpected frame d%0d", g), 1, 0);
          end else begin
            e = exp_q[g].pop_front();
            if (e.gap >= 0) chk($sformatf("idle gap d%0d", g), cyc - dn, e.gap);
            bad = 0;
            ab  = 1'b0;
            for (int c = 0; c < e.n * e.len; c++) begin
              if (c > 0) @(negedge clk);
              if (rst) begin ab = 1'b1; break; end
              if (tx_w[g] !== e.bits[c / e.len] || done_w[g] !== 1'b0) bad++;
            end
            chk($sformatf("abort d%0d", g), ab, e.may_abort);
            if (!ab) begin
              chk($sformatf("frame bits d%0d", g), bad, 0);
              @(negedge clk);
              chk($sformatf("done pulse d%0d", g), {done_w[g], tx_w[g]}, 2'b11);
              dn = cyc;
            end
          end
        end
        prev = (tx_w[g] === 1'b1);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    bit seen;
    rst = 1'b1; tvalid = '0; tdata = '0; div4 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset tx", tx_w, 4'hF);
    chk("reset busy", busy_w, 4'h0);
    chk("reset done", done_w, 4'h0);
    chk("reset ready", rdy_w, 4'hF);
    rst = 1'b0;

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    expect_frame(0, 12'b00_1101001010, 10, 16, -1, 0);
    send(0, 9'h0A5, 0);
    wait_idle(0);

    // 8E1: 0x07 -> parity 1, 0x03 -> parity 0
    expect_frame(1, 12'b0_1_1_00000111_0, 11, 16, -1, 0);
    expect_frame(1, 12'b0_1_0_00000011_0, 11, 16, 1, 0);
    send(1, 9'h007, 0);
    send(1, 9'h003, 0);
    wait_idle(1);

    // 8O1: 0x07 -> parity 0, 0x00 -> parity 1
    expect_frame(2, 12'b0_1_0_00000111_0, 11, 16, -1, 0);
    expect_frame(2, 12'b0_1_1_00000000_0, 11, 16, 1, 0);
    send(2, 9'h007, 0);
    send(2, 9'h000, 0);
    wait_idle(2);

    // 5N2: 0x1F and 0x0A, stop high for 32 clk
    expect_frame(3, 12'b0000_11_11111_0, 8, 16, -1, 0);
    expect_frame(3, 12'b0000_11_01010_0, 8, 16, 1, 0);
    send(3, 9'h01F, 0);
    send(3, 9'h00A, 0);
    wait_idle(3);

    // baud_tick every 4th clk: 64 clk per bit, 0x96
    div4 = 1'b1;
    expect_frame(0, 12'b00_1100101100, 10, 64, -1, 0);
    send(0, 9'h096, 1);
    wait_idle(0);
    div4 = 1'b0;

    // rst 50 clk into a frame, then a clean frame
    expect_frame(0, 12'b00_1010110100, 10, 16, -1, 1);
    send(0, 9'h05A, 0);
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort tx", tx_w[0], 1);
    chk("abort busy", busy_w[0], 0);
    chk("abort ready", rdy_w[0], 1);
    rst = 1'b0;
    expect_frame(0, 12'b00_1011010010, 10, 16, -1, 0);
    send(0, 9'h069, 0);
    wait_idle(0);

    // rst wins over a simultaneous handshake
    @(posedge clk); #1;
    rst = 1'b1; tdata = 9'h0FF; tvalid[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst priority busy", busy_w[0], 0);
    rst = 1'b0; tvalid[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("rst priority no frame", busy_w[0], 0);

`ifdef UART_TX_FIFO_EN
    // frame 1 in flight, four words fill the FIFO, fifth is refused
    expect_frame(0, 12'b00_1101001010, 10, 16, -1, 0);
    expect_frame(0, 12'b00_1000100010, 10, 16, 1, 0);
    expect_frame(0, 12'b00_1001000100, 10, 16, 1, 0);
    expect_frame(0, 12'b00_1001100110, 10, 16, 1, 0);
    expect_frame(0, 12'b00_1010001000, 10, 16, 1, 0);
    send(0, 9'h0A5, 0);
    for (int i = 0; i < 5; i++) begin
      tdata = 9'((i + 1) * 9'h011);
      tvalid[0] = 1'b1;
      chk($sformatf("fifo ready push %0d", i), rdy_w[0], (i < 4) ? 1 : 0);
      @(posedge clk); #1;
    end
    tvalid[0] = 1'b0;
    wait_idle(0);
`else
    // valid held through a frame: no second handshake until done
    expect_frame(0, 12'b00_1001111000, 10, 16, -1, 0);
    expect_frame(0, 12'b00_1110000110, 10, 16, 1, 0);
    @(posedge clk); #1;
    tdata = 9'h03C; tvalid[0] = 1'b1;
    @(posedge clk); #1;
    extra = 0; seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_w[0]) begin seen = 1'b1; break; end
      if (rdy_w[0]) extra++;
      @(posedge clk); #1;
    end
    chk("ready while busy", extra, 0);
    chk("done seen", seen, 1);
    tdata = 9'h0C3;
    @(posedge clk); #1;
    tvalid[0] = 1'b0;
    wait_idle(0);
`endif

    repeat (5) @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("pending frames d%0d", k), exp_q[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
